// File: rtl/edp_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// edp_muldiv_pkg
// Shared encodings for the EBOX iterative multiply/divide sequencer:
//   op_e       operation select captured with start
//   state_e    sequencer states, plus plain logic [2:0] aliases
//   ctr_width  width of the step down-counter for a given WIDTH/RADIX_BITS
// ---------------------------------------------------------------------------
package edp_muldiv_pkg;

  typedef enum logic [1:0] {
    opMULS = 2'b00,
    opMULU = 2'b01,
    opDIVS = 2'b10,
    opDIVU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    stIDLE = 3'd0,
    stPREP = 3'd1,
    stSTEP = 3'd2,
    stFIX  = 3'd3,
    stDONE = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE = stIDLE;
  localparam logic [2:0] ST_PREP = stPREP;
  localparam logic [2:0] ST_STEP = stSTEP;
  localparam logic [2:0] ST_FIX  = stFIX;
  localparam logic [2:0] ST_DONE = stDONE;

  // Counter must hold the full step count WIDTH/RADIX_BITS.
  function automatic int ctr_width(input int width, input int radix_bits);
    return $clog2(width / radix_bits + 1);
  endfunction

endpackage

// File: rtl/edp_muldiv_seq_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational multiply or divide step on a 2*WIDTH accumulator
// {hi, lo}.
//   MUL: if lo[0], hi += opnd (WIDTH+1-bit sum, so no carry is lost); then
//        the whole {carry, hi, lo} shifts right one place.
//   DIV: restoring step. {hi, lo} shifts left one place, opnd is trial
//        subtracted from the WIDTH+1-bit partial remainder, and the
//        difference is kept when it is non-negative.
// Ports:
//   i_acc   [2*WIDTH-1:0]  accumulator in
//   i_opnd  [WIDTH-1:0]    multiplicand or divisor magnitude
//   i_div   1              1 = divide step, 0 = multiply step
//   o_acc   [2*WIDTH-1:0]  accumulator out (DIV: LSB left 0 for o_qbit)
//   o_qbit  1              quotient bit of this step (0 for MUL)
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 36
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH+1:0] w_diff;

  assign w_hi  = i_acc[2*WIDTH-1:WIDTH];
  assign w_lo  = i_acc[WIDTH-1:0];
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : '0);
  assign w_shl = {w_hi, w_lo[WIDTH-1]};
  assign w_diff = {1'b0, w_shl} - {2'b00, i_opnd};

  always_comb begin
    o_qbit = 1'b0;
    o_acc  = {w_sum, w_lo[WIDTH-1:1]};
    if (i_div) begin
      // A kept difference is below the divisor, so its top two bits are 0.
      o_qbit = (w_diff[WIDTH+1:WIDTH] == 2'b00);
      o_acc  = {(o_qbit ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0]),
                w_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/edp_muldiv_seq.sv
// ---------------------------------------------------------------------------
// edp_muldiv_seq
// Iterative multiply/divide sequencer for the EBOX data path. The operands
// are reduced to magnitudes, run through WIDTH/RADIX_BITS shift-add or
// restoring-divide steps, then sign-corrected.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands captured when it is accepted
//   PREP  | magnitudes, result signs, counter load, divide check
//   STEP  | RADIX_BITS chained steps per clock until the counter hits 1
//   FIX   | two's-complement sign fixup, result registers written
//   DONE  | done pulse for one clock, then back to IDLE
//
// Ports:
//   eboxClk, eboxReset         clock, synchronous active-high reset
//   start, abort               request (IDLE only) / cancel
//   op[1:0]                    00 MULS, 01 MULU, 10 DIVS, 11 DIVU
//   opA, opB [0:WIDTH-1]       multiplicand/dividend, multiplier/divisor
//   busy, done                 in progress / one-cycle result strobe
//   resHi, resLo [0:WIDTH-1]   product hi/lo, or quotient/remainder
//   divCheck                   divide refused (held until next start)
// ---------------------------------------------------------------------------
module edp_muldiv_seq
  import edp_muldiv_pkg::*;
#(
  parameter int WIDTH      = 36,
  parameter int RADIX_BITS = 1
) (
  input  logic             eboxClk,
  input  logic             eboxReset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] resHi,
  output logic [0:WIDTH-1] resLo,
  output logic             divCheck
);

  localparam int NSTEPS = WIDTH / RADIX_BITS;
  localparam int CW     = ctr_width(WIDTH, RADIX_BITS);

  logic [2:0]         r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_hi;
  logic               r_neg_lo;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   r_res_lo;
  logic               r_div_check;

  logic               w_is_div;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_refuse;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_sa     = w_signed & r_a[WIDTH-1];
  assign w_sb     = w_signed & r_b[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a  = w_sa ? (~r_a + 1'b1) : r_a;
  assign w_mag_b  = w_sb ? (~r_b + 1'b1) : r_b;

  // Zero divisor, or the one signed quotient that cannot be represented.
  assign w_refuse = w_is_div &
                    ((r_b == '0) |
                     ((r_op == opDIVS) && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (r_b == '1)));

  assign w_prod = r_neg_hi ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_hi ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_lo ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                           : r_acc[2*WIDTH-1:WIDTH];

  logic [2*WIDTH-1:0] w_chain     [RADIX_BITS+1];
  logic [2*WIDTH-1:0] w_stage_acc [RADIX_BITS];
  logic               w_stage_q   [RADIX_BITS];

  assign w_chain[0] = r_acc;

  for (genvar k = 0; k < RADIX_BITS; k++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_acc  (w_chain[k]),
      .i_opnd (r_opnd),
      .i_div  (w_is_div),
      .o_acc  (w_stage_acc[k]),
      .o_qbit (w_stage_q[k])
    );
    // Quotient bit drops into the LSB vacated by the divide shift.
    assign w_chain[k+1] = w_stage_acc[k] | {{(2*WIDTH-1){1'b0}}, w_stage_q[k]};
  end

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_neg_hi    <= 1'b0;
      r_neg_lo    <= 1'b0;
      r_cnt       <= '0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_div_check <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op        <= op;
            r_a         <= opA;
            r_b         <= opB;
            r_div_check <= 1'b0;
            r_state     <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_cnt    <= CW'(NSTEPS);
          r_neg_hi <= w_sa ^ w_sb;
          r_neg_lo <= w_sa;
          if (w_is_div) begin
            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            r_opnd <= w_mag_b;
          end else begin
            r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            r_opnd <= w_mag_a;
          end
          if (w_refuse) begin
            r_div_check <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_acc <= w_chain[RADIX_BITS];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (w_is_div) begin
            r_res_hi <= w_quo;
            r_res_lo <= w_rem;
          end else begin
            r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_res_lo <= w_prod[WIDTH-1:0];
          end
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == ST_PREP) | (r_state == ST_STEP) | (r_state == ST_FIX);
  assign done     = (r_state == ST_DONE);
  assign resHi    = r_res_hi;
  assign resLo    = r_res_lo;
  assign divCheck = r_div_check;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
module tb_edp_muldiv_seq;

  localparam int W = 36;

  logic         eboxClk = 1'b0;
  logic         eboxReset;
  logic         start;
  logic         abort;
  logic [1:0]   op;
  logic [0:W-1] opA;
  logic [0:W-1] opB;

  logic         busy1, done1, dc1;
  logic [0:W-1] hi1, lo1;
  logic         busy2, done2, dc2;
  logic [0:W-1] hi2, lo2;

  always #5 eboxClk = ~eboxClk;

  edp_muldiv_seq #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .start(start), .abort(abort),
    .op(op), .opA(opA), .opB(opB), .busy(busy1), .done(done1),
    .resHi(hi1), .resLo(lo1), .divCheck(dc1));

  edp_muldiv_seq #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .start(start), .abort(abort),
    .op(op), .opA(opA), .opB(opB), .busy(busy2), .done(done2),
    .resHi(hi2), .resLo(lo2), .divCheck(dc2));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dc;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  always @(posedge eboxClk) cyc++;

  // Reference: plain wide arithmetic, SV '/' and '%' truncate toward zero.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] ph,
                                 input logic [W-1:0] pl);
    exp_t e;
    logic signed [2*W-1:0] xa, xb, p;
    logic [W-1:0] minv;
    longint sa, sbv, q, r;
    minv = {1'b1, {(W-1){1'b0}}};
    e.dc = 1'b0; e.lat = 0; e.t0 = 0; e.hi = ph; e.lo = pl;
    if (!o[1]) begin
      if (!o[0]) begin
        xa = {{W{a[W-1]}}, a};
        xb = {{W{b[W-1]}}, b};
      end else begin
        xa = {{W{1'b0}}, a};
        xb = {{W{1'b0}}, b};
      end
      p = xa * xb;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else begin
      if (!o[0]) begin
        sa = $signed(a);
        sbv = $signed(b);
      end else begin
        sa = a;
        sbv = b;
      end
      if (b == '0 || (!o[0] && a == minv && b == '1)) begin
        e.dc = 1'b1;
      end else begin
        q = sa / sbv;
        r = sa % sbv;
        e.hi = q[W-1:0];
        e.lo = r[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic cmp(input int which, input exp_t e, input logic [W-1:0] hi,
                     input logic [W-1:0] lo, input logic dcv, input logic bv);
    int lat;
    lat = cyc - e.t0;
    vecs++;
    if (hi !== e.hi || lo !== e.lo || dcv !== e.dc || lat != e.lat || bv !== 1'b0) begin
      errs++;
      $display("FAIL result_r%0d: got hi=%o lo=%o dc=%b lat=%0d busy=%b, want hi=%o lo=%o dc=%b lat=%0d busy=0",
               which, hi, lo, dcv, lat, bv, e.hi, e.lo, e.dc, e.lat);
    end
  endtask

  always @(negedge eboxClk) begin
    if (done1) begin
      if (sb1.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_done_r1: got done=1 at cycle %0d, want no done", cyc);
      end else cmp(1, sb1.pop_front(), hi1, lo1, dc1, busy1);
    end
  end

  always @(negedge eboxClk) begin
    if (done2) begin
      if (sb2.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_done_r2: got done=1 at cycle %0d, want no done", cyc);
      end else cmp(2, sb2.pop_front(), hi2, lo2, dc2, busy2);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_it);
    exp_t e, e1, e2;
    @(negedge eboxClk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge eboxClk);
    start = 1'b0;
    if (expect_it) begin
      e = model(o, a, b, prev_hi, prev_lo);
      e.t0 = cyc;
      e1 = e; e1.lat = e.dc ? 1 : W + 2;
      e2 = e; e2.lat = e.dc ? 1 : W / 2 + 2;
      sb1.push_back(e1);
      sb2.push_back(e2);
      if (!e.dc) begin
        prev_hi = e.hi;
        prev_lo = e.lo;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || done1 || busy2 || done2) && n < 200) begin
      @(negedge eboxClk);
      n++;
    end
    if (n >= 200) begin
      vecs++; errs++;
      $display("FAIL idle_timeout: got busy still high after %0d cycles, want idle", n);
    end
  endtask

  task automatic check_static(input string tag, input logic [W-1:0] ehi,
                              input logic [W-1:0] elo, input logic edc);
    vecs++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || hi1 !== ehi || lo1 !== elo || dc1 !== edc) begin
      errs++;
      $display("FAIL %s_r1: got busy=%b done=%b hi=%o lo=%o dc=%b, want busy=0 done=0 hi=%o lo=%o dc=%b",
               tag, busy1, done1, hi1, lo1, dc1, ehi, elo, edc);
    end
    vecs++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || hi2 !== ehi || lo2 !== elo || dc2 !== edc) begin
      errs++;
      $display("FAIL %s_r2: got busy=%b done=%b hi=%o lo=%o dc=%b, want busy=0 done=0 hi=%o lo=%o dc=%b",
               tag, busy2, done2, hi2, lo2, dc2, ehi, elo, edc);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom_range(0, 20));
      default: return t[W-1:0];
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    eboxReset = 1'b1; start = 1'b0; abort = 1'b0;
    op = 2'b00; opA = '0; opB = '0;
    repeat (3) @(negedge eboxClk);
    eboxReset = 1'b0;
    check_static("reset", '0, '0, 1'b0);

    // Directed vectors
    issue(2'b00, 36'o000000000003, 36'o777777777773, 1); wait_idle();
    issue(2'b01, 36'o777777777777, 36'o777777777777, 1); wait_idle();
    issue(2'b10, 36'o777777777771, 36'o000000000002, 1); wait_idle();
    issue(2'b11, 36'd100, 36'd7, 1); wait_idle();
    issue(2'b10, 36'd5, 36'd0, 1); wait_idle();
    issue(2'b10, 36'o400000000000, 36'o777777777777, 1); wait_idle();
    issue(2'b11, 36'd9, 36'd0, 1); wait_idle();
    issue(2'b00, 36'o400000000000, 36'o400000000000, 1); wait_idle();

    // Abort at step 10: no done, outputs and cleared divCheck held
    issue(2'b00, 36'd1234, 36'd567, 0);
    repeat (10) @(negedge eboxClk);
    abort = 1'b1;
    @(negedge eboxClk);
    abort = 1'b0;
    check_static("abort", prev_hi, prev_lo, 1'b0);
    repeat (50) @(negedge eboxClk);

    // Start while busy is ignored
    issue(2'b10, 36'd1000, 36'o777777777775, 1);
    repeat (5) @(negedge eboxClk);
    op = 2'b01; opA = 36'd77; opB = 36'd88; start = 1'b1;
    @(negedge eboxClk);
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1);
      wait_idle();
    end

    // Reset mid-STEP clears everything
    issue(2'b01, 36'd4321, 36'd8765, 0);
    repeat (8) @(negedge eboxClk);
    eboxReset = 1'b1;
    @(negedge eboxClk);
    check_static("midreset", '0, '0, 1'b0);
    eboxReset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;

    issue(2'b10, 36'd0, 36'd0, 1); wait_idle();
    issue(2'b00, 36'o777777777777, 36'd2, 1); wait_idle();

    repeat (5) @(negedge eboxClk);
    vecs++;
    if (sb1.size() != 0 || sb2.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending results, want 0/0", sb1.size(), sb2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
